// File: rtl/sr_mutex_arbiter.sv
// sr_mutex_arbiter: round-robin mutex that shares one resource among N requesters.
// Ownership lives in SR-style grant flags: a grant sets the owner's flag, and a release or
// timeout clears it. If set and clear could coincide, clear wins.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   req[N]         level requests, sampled only while idle
//   rel[N]         release strobes, only rel[owner] is honoured
//   gnt[N]         registered one-hot grant, zero when nobody owns the resource
//   gnt_id[IDW]    index of the current owner, keeps the last owner while idle
//   busy           high while a grant is held
//   timeout_pulse  one-cycle pulse when an owner is force-released
//   err_rel        one-cycle pulse, one cycle after a rel from a non-owner or while idle
module sr_mutex_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout_pulse,
    output logic                 err_rel
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // With the timeout disabled, the counter is pinned at zero and never compared.
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE     = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  last_owner;

    logic [IDW-1:0]  win;
    logic            found;
    logic            rel_owner;
    logic            timeout_hit;
    logic            err_cond;

    // Search starts just after the last owner, so the previous owner ranks lowest.
    always_comb begin : pick_blk
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (int'(last_owner) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        rel_owner   = (state == StHold) && rel[gnt_id];
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_MAX);
        // gnt is one-hot while holding, so rel & ~gnt isolates every non-owner strobe.
        err_cond    = (state == StHold) ? |(rel & ~gnt) : |rel;
    end

    assign busy = |gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            cnt           <= '0;
            last_owner    <= IDW'(N - 1);
            gnt           <= '0;
            gnt_id        <= '0;
            timeout_pulse <= 1'b0;
            err_rel       <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            err_rel       <= err_cond;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        gnt        <= ONE << win;
                        gnt_id     <= win;
                        last_owner <= win;
                        cnt        <= '0;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    // A release takes precedence over a same-cycle timeout and suppresses the pulse.
                    if (rel_owner) begin
                        gnt   <= '0;
                        state <= StIdle;
                    end else if (timeout_hit) begin
                        gnt           <= '0;
                        timeout_pulse <= 1'b1;
                        state         <= StIdle;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
